// File: rtl/hdlc_rxbuf_reader.sv
// HDLC receive-buffer reader: fetches the length word, CRC-checks the frame, then streams the payload.
// Optional HDLC_RD_STATS_EN adds saturating good/bad frame counters.
module hdlc_rxbuf_reader #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned LEN_LO_ADDR = 510,
  parameter int unsigned LEN_HI_ADDR = 511,
  parameter int unsigned MIN_LEN     = 3,
  parameter int unsigned MAX_LEN     = 508,
  parameter logic [15:0] CRC_RESIDUE = 16'hF0B8
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              rx_int,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [7:0]        ram_rd_data,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              frame_done,
  output logic              frame_ok,
  output logic [8:0]        frame_len,
  output logic [1:0]        err_code,
  output logic              overrun,
  output logic              busy
`ifdef HDLC_RD_STATS_EN
  ,
  output logic [15:0]       good_cnt,
  output logic [15:0]       bad_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, RD_LEN, CHKLEN, CRC, STREAM, DONE} state_t;

  state_t            state;
  logic [1:0]        int_sync;
  logic              int_sync_d;
  logic              int_edge;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_last;
  logic              rd_more;
  logic              rd_vld;
  logic [8:0]        rx_idx;
  logic [8:0]        count;
  logic [7:0]        len_lo;
  logic [15:0]       crc;
  logic [15:0]       crc_nxt;
  logic [7:0]        sk_data;
  logic              sk_last;
  logic              sk_vld;
  logic              pop;
  logic              push;
  logic              push_last;
  logic [2:0]        occ;
  logic              room;

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Read enable is decoded from registered state plus the current pop so the
  // 2-entry skid buffer sustains one byte per cycle with 1-cycle RAM latency.
  always_comb begin
    int_edge    = int_sync[1] & ~int_sync_d;
    pop         = m_tvalid && m_tready;
    push        = rd_vld && (state == STREAM);
    push_last   = (rx_idx == count - 9'd3);
    occ         = 3'(m_tvalid) + 3'(sk_vld) + 3'(rd_vld) - 3'(pop);
    room        = (state != STREAM) || (occ < 3'd2);
    ram_rd_en   = rd_more && room;
    ram_rd_addr = rd_addr;
    crc_nxt     = crc_byte(crc, ram_rd_data);
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      int_sync   <= '0;
      int_sync_d <= 1'b0;
      rd_addr    <= '0;
      rd_last    <= '0;
      rd_more    <= 1'b0;
      rd_vld     <= 1'b0;
      rx_idx     <= '0;
      count      <= '0;
      len_lo     <= '0;
      crc        <= '1;
      sk_data    <= '0;
      sk_last    <= 1'b0;
      sk_vld     <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= '0;
      err_code   <= '0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      int_sync   <= {int_sync[0], rx_int};
      int_sync_d <= int_sync[1];
      rd_vld     <= ram_rd_en;
      frame_done <= 1'b0;
      overrun    <= int_edge && (state != IDLE);

      if (ram_rd_en) begin
        if (rd_addr == rd_last) rd_more <= 1'b0;
        else                    rd_addr <= rd_addr + ADDR_W'(1);
      end
      if (rd_vld) rx_idx <= rx_idx + 9'd1;

      if (!m_tvalid || m_tready) begin
        if (sk_vld) begin
          m_tdata  <= sk_data;
          m_tlast  <= sk_last;
          m_tvalid <= 1'b1;
          sk_vld   <= push;
          if (push) begin
            sk_data <= ram_rd_data;
            sk_last <= push_last;
          end
        end else begin
          m_tvalid <= push;
          m_tlast  <= push && push_last;
          if (push) m_tdata <= ram_rd_data;
        end
      end else if (push) begin
        sk_data <= ram_rd_data;
        sk_last <= push_last;
        sk_vld  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (int_edge) begin
            state   <= RD_LEN;
            busy    <= 1'b1;
            rd_addr <= ADDR_W'(LEN_LO_ADDR);
            rd_last <= ADDR_W'(LEN_HI_ADDR);
            rd_more <= 1'b1;
            rx_idx  <= '0;
          end
        end
        RD_LEN: begin
          if (rd_vld) begin
            if (rx_idx == 9'd0) begin
              len_lo <= ram_rd_data;
            end else begin
              count <= {ram_rd_data[0], len_lo};
              state <= CHKLEN;
            end
          end
        end
        CHKLEN: begin
          if (count < 9'(MIN_LEN) || count > 9'(MAX_LEN)) begin
            state      <= DONE;
            frame_done <= 1'b1;
            frame_ok   <= 1'b0;
            err_code   <= 2'd2;
            frame_len  <= (count >= 9'd2) ? count - 9'd2 : '0;
          end else begin
            state   <= CRC;
            crc     <= '1;
            rd_addr <= '0;
            rd_last <= ADDR_W'(count - 9'd1);
            rd_more <= 1'b1;
            rx_idx  <= '0;
          end
        end
        CRC: begin
          if (rd_vld) begin
            crc <= crc_nxt;
            if (rx_idx == count - 9'd1) begin
              frame_len <= count - 9'd2;
              if (crc_nxt == CRC_RESIDUE) begin
                state   <= STREAM;
                rd_addr <= '0;
                rd_last <= ADDR_W'(count - 9'd3);
                rd_more <= 1'b1;
                rx_idx  <= '0;
              end else begin
                state      <= DONE;
                frame_done <= 1'b1;
                frame_ok   <= 1'b0;
                err_code   <= 2'd1;
              end
            end
          end
        end
        STREAM: begin
          if (pop && m_tlast) begin
            state      <= DONE;
            frame_done <= 1'b1;
            frame_ok   <= 1'b1;
            err_code   <= 2'd0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HDLC_RD_STATS_EN
  logic [16:0] bad_sum;

  always_comb begin
    bad_sum = 17'(bad_cnt) + 17'(frame_done && !frame_ok) + 17'(overrun);
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (frame_done && frame_ok && good_cnt != '1) good_cnt <= good_cnt + 16'd1;
      bad_cnt <= bad_sum[16] ? '1 : bad_sum[15:0];
    end
  end
`endif

endmodule
